// File: rtl/calc_sequencer.sv
// calc_sequencer: in-order command sequencer for the 4-bit combinational calculator.
// Commands are queued in a small FIFO and popped one at a time. Illegal opcodes and
// divide/mod-by-zero are rejected before they reach the datapath. Legal operands are
// held on calc_* for CALC_LAT cycles, then calc_out is captured and returned over a
// valid/ready response port.
module calc_sequencer #(
  parameter int CALC_LAT   = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_a,
  input  logic [3:0]  cmd_b,
  input  logic [2:0]  cmd_oper,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_err,
  output logic [3:0]  calc_a,
  output logic [3:0]  calc_b,
  output logic [2:0]  calc_oper,
  input  logic [7:0]  calc_out,
  output logic        busy,
  output logic [15:0] done_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CALC_LAT + 1);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] oper;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_nempty;

  state_t        state;
  cmd_t          op;
  logic [CW-1:0] wcnt;

  assign fifo_nempty = (count != '0);
  assign cmd_ready   = (count != (AW+1)'(FIFO_DEPTH));
  assign push        = cmd_valid && cmd_ready;
  // The head is only consumed while the FSM is idle, which keeps responses in order.
  assign pop         = (state == IDLE) && fifo_nempty;
  assign busy        = (state != IDLE) || fifo_nempty;

  // FIFO storage: written on accept; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{a: cmd_a, b: cmd_b, oper: cmd_oper};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == AW'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == AW'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencing FSM with registered calculator drive, response and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= '0;
      calc_a    <= '0;
      calc_b    <= '0;
      calc_oper <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_nempty) begin
            op    <= mem[rptr];
            state <= CHECK;
          end
        end
        CHECK: begin
          if (op.oper[2:1] == 2'b11) begin
            rsp_err   <= 2'b10;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if ((op.oper == 3'd3 || op.oper == 3'd4) && op.b == 4'd0) begin
            rsp_err   <= 2'b01;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            calc_a    <= op.a;
            calc_b    <= op.b;
            calc_oper <= op.oper;
            wcnt      <= CW'(CALC_LAT);
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Last settle cycle: calculator output has been stable for CALC_LAT cycles.
          if (wcnt == CW'(1)) begin
            rsp_data  <= calc_out;
            rsp_err   <= 2'b00;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
            calc_a    <= '0;
            calc_b    <= '0;
            calc_oper <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed latency/error/backpressure/reset cases plus randomized
// traffic, all responses scored against an in-order queue of expected results.
module tb_calc_sequencer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [3:0]  cmd_a, cmd_b, calc_a, calc_b;
  logic [2:0]  cmd_oper, calc_oper;
  logic [7:0]  rsp_data, calc_out;
  logic [1:0]  rsp_err;
  logic [15:0] done_cnt;

  int checks = 0, errors = 0;
  int tb_done = 0, acc_cnt = 0, viol = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  calc_sequencer #(.CALC_LAT(LAT), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .calc_a(calc_a), .calc_b(calc_b), .calc_oper(calc_oper),
    .calc_out(calc_out), .busy(busy), .done_cnt(done_cnt)
  );

  // Behavioural combinational calculator.
  always_comb begin
    calc_out = 8'hFF;
    case (calc_oper)
      3'd0: calc_out = 8'(calc_a) + 8'(calc_b);
      3'd1: calc_out = 8'(calc_a) - 8'(calc_b);
      3'd2: calc_out = 8'(calc_a) * 8'(calc_b);
      3'd3: if (calc_b != 0) calc_out = 8'(calc_a / calc_b);
      3'd4: if (calc_b != 0) calc_out = 8'(calc_a % calc_b);
      3'd5: calc_out = {4'h0, ~calc_a};
      default: calc_out = 8'hFF;
    endcase
  end

  // Expected {err, data} for one command.
  function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ia = a, ib = b, r;
    if (op >= 3'd6) return {2'b10, 8'h00};
    if ((op == 3'd3 || op == 3'd4) && ib == 0) return {2'b01, 8'h00};
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = (ia - ib + 256) % 256;
      3'd2: r = ia * ib;
      3'd3: r = ia / ib;
      3'd4: r = ia % ib;
      default: r = 15 - ia;
    endcase
    return {2'b00, 8'(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard/monitor sampled mid-cycle, when inputs and outputs are both settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (calc_oper > 3'd5 || ((calc_oper == 3'd3 || calc_oper == 3'd4) && calc_b == 4'd0)) viol++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
          chk("rsp_err", 32'(rsp_err), 32'(e[9:8]));
        end
        tb_done++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(model(cmd_a, cmd_b, cmd_oper));
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One command on an idle sequencer with rsp_ready=1; checks latency and result.
  task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input int exp_lat);
    int k;
    logic [9:0] e;
    e = model(a, b, op);
    rsp_ready = 1'b1;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_a = a; cmd_b = b; cmd_oper = op; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
      if (k == 2 && exp_lat > 2) begin
        chk({tag, "_calc_a"}, 32'(calc_a), 32'(a));
        chk({tag, "_calc_oper"}, 32'(calc_oper), 32'(op));
      end
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
    chk({tag, "_data"}, 32'(rsp_data), 32'(e[7:0]));
    chk({tag, "_err"}, 32'(rsp_err), 32'(e[9:8]));
    tick();
    tick();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((busy || rsp_valid) && k < 500) begin
      tick();
      k++;
    end
    chk({tag, "_drain_timeout"}, 32'(k < 500), 32'd1);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(tb_done));
  endtask

  initial begin
    int dc, k;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_oper = '0;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_calc", 32'({calc_a, calc_b, calc_oper}), 32'd0);
    chk("rst_rsp", 32'({rsp_data, rsp_err}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // Directed cases
    run_one("add", 4'd3, 4'd4, 3'd0, 2 + LAT);
    run_one("sub", 4'd2, 4'd5, 3'd1, 2 + LAT);
    run_one("mul", 4'd15, 4'd15, 3'd2, 2 + LAT);
    run_one("div0", 4'd9, 4'd0, 3'd3, 2);
    run_one("mod", 4'd9, 4'd4, 3'd4, 2 + LAT);
    run_one("nota", 4'd5, 4'd0, 3'd5, 2 + LAT);
    dc = done_cnt;
    run_one("ill", 4'd1, 4'd1, 3'd7, 2);
    chk("ill_done_inc", 32'(done_cnt), 32'(dc + 1));
    chk("dir_done_cnt", 32'(done_cnt), 32'(tb_done));

    // Backpressure: response held, FIFO fills after three accepts
    rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_a = 4'($urandom); cmd_b = 4'($urandom_range(1, 15));
      cmd_oper = 3'($urandom_range(0, 5)); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepts", 32'(acc_cnt), 32'd3);
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    drain("bp");

    // Randomized traffic with random response backpressure
    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom);
      cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      if (($urandom % 4) == 0) cmd_b = 4'd0;
      cmd_oper = 3'($urandom);
      rsp_ready = (($urandom % 4) != 0);
      tick();
    end
    drain("rnd");
    chk("no_bad_calc_oper", 32'(viol), 32'd0);

    // Reset during WAIT drops the op
    rsp_ready = 1'b1;
    cmd_a = 4'd5; cmd_b = 4'd3; cmd_oper = 3'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (calc_oper != 3'd2 && k < 10) begin
      tick();
      k++;
    end
    chk("wait_reached", 32'(calc_oper), 32'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tb_done = 0;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_calc", 32'({calc_a, calc_b, calc_oper}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_one("post_rst_add", 4'd1, 4'd2, 3'd0, 2 + LAT);
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
